// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the round-robin register-bank write arbiter.
package reg_write_arbiter_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 4;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PTR_W_DEF = ptr_width(NUM_REQ_DEF);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2,
      ST_INIT  = 2'd3
   } state_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester / register-bank side bundle of the write arbiter.
// master: requesters plus the bank q; slave: the arbiter.
interface reg_write_arbiter_if
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF
);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [DATA_W-1:0]         reg_q;
   logic [DATA_W-1:0]         reg_d;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic                      busy;

   modport master (
      output req,
      output wdata,
      output reg_q,
      input  reg_d,
      input  gnt,
      input  ack,
      input  busy
   );

   modport slave (
      input  req,
      input  wdata,
      input  reg_q,
      output reg_d,
      output gnt,
      output ack,
      output busy
   );

endinterface

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr,
// wrapping modulo NUM_REQ.
module rr_priority_pick
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [PTR_W-1:0]   win_idx,
   output logic               win_valid
);

   int scan_idx;

   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
      win_valid  = 1'b0;
      scan_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(ptr) + k) % NUM_REQ;
         if (!win_valid && req[scan_idx]) begin
            win_valid            = 1'b1;
            win_onehot[scan_idx] = 1'b1;
            win_idx              = PTR_W'(scan_idx);
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write sequencer driving the d input of an enable-less register bank.
// Optional reset-time init write: REG_WRITE_ARBITER_INIT_WRITE_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | reg_d recirculates reg_q; arbitrate pending requests
// ST_WRITE | reg_d = wbuf, one-hot gnt high, bank captures at cycle end
// ST_ACK   | reg_d recirculates (now == wbuf), one-hot ack pulse
// ST_INIT  | reg_d = RESET_VAL for one cycle after reset (option only)
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int                NUM_REQ   = NUM_REQ_DEF,
   parameter int                DATA_W    = DATA_W_DEF,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   reg_write_arbiter_if.slave bus
);

   localparam int PTR_W = ptr_width(NUM_REQ);

`ifdef REG_WRITE_ARBITER_INIT_WRITE_EN
   localparam state_t RST_STATE = ST_INIT;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   state_t              state;
   state_t              state_nxt;
   logic [NUM_REQ-1:0]  gnt_r;
   logic [NUM_REQ-1:0]  gnt_nxt;
   logic [NUM_REQ-1:0]  ack_r;
   logic [NUM_REQ-1:0]  ack_nxt;
   logic                busy_r;
   logic                busy_nxt;
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    ptr_nxt;
   logic [PTR_W-1:0]    win_idx;
   logic [PTR_W-1:0]    win_idx_nxt;
   logic [DATA_W-1:0]   wbuf;
   logic [DATA_W-1:0]   wbuf_nxt;

   logic [NUM_REQ-1:0]  pick_onehot;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_valid;
   logic [DATA_W-1:0]   wdata_sel;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req        (bus.req),
      .ptr        (ptr),
      .win_onehot (pick_onehot),
      .win_idx    (pick_idx),
      .win_valid  (pick_valid)
   );

   assign wdata_sel = bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RST_STATE;
         gnt_r   <= '0;
         ack_r   <= '0;
         busy_r  <= RST_BUSY;
         ptr     <= '0;
         win_idx <= '0;
         wbuf    <= '0;
      end else begin
         state   <= state_nxt;
         gnt_r   <= gnt_nxt;
         ack_r   <= ack_nxt;
         busy_r  <= busy_nxt;
         ptr     <= ptr_nxt;
         win_idx <= win_idx_nxt;
         wbuf    <= wbuf_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = '0;
      ack_nxt     = '0;
      ptr_nxt     = ptr;
      win_idx_nxt = win_idx;
      wbuf_nxt    = wbuf;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nxt   = ST_WRITE;
               gnt_nxt     = pick_onehot;
               win_idx_nxt = pick_idx;
               wbuf_nxt    = wdata_sel;
            end
         end
         ST_WRITE: begin
            state_nxt = ST_ACK;
            ack_nxt   = gnt_r;
         end
         ST_ACK: begin
            state_nxt = ST_IDLE;
            // just-served requester drops to lowest priority
            if (int'(win_idx) >= NUM_REQ - 1) begin
               ptr_nxt = '0;
            end else begin
               ptr_nxt = win_idx + 1'b1;
            end
         end
         ST_INIT: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // rst gates reg_d so the bank holds its value while reset is asserted
   always_comb begin
      bus.reg_d = bus.reg_q;
      if (!rst) begin
         case (state)
            ST_WRITE: bus.reg_d = wbuf;
`ifdef REG_WRITE_ARBITER_INIT_WRITE_EN
            ST_INIT:  bus.reg_d = RESET_VAL;
`endif
            default:  bus.reg_d = bus.reg_q;
         endcase
      end
   end

   assign bus.gnt  = gnt_r;
   assign bus.ack  = ack_r;
   assign bus.busy = busy_r;

   a_gnt_ack_excl: assert property (@(posedge clk) disable iff (rst)
      !((|gnt_r) && (|ack_r)));
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt_r));
   a_ack_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(ack_r));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural enable-less register bank.
// Expectations adapt when REG_WRITE_ARBITER_INIT_WRITE_EN is defined.
module tb_reg_write_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ack_cnt = 0;
   bit   mon_en = 1'b0;

`ifdef REG_WRITE_ARBITER_INIT_WRITE_EN
   localparam int RST_BUSY = 1;
`else
   localparam int RST_BUSY = 0;
`endif

   reg_write_arbiter_if #(.NUM_REQ(4), .DATA_W(4)) bif ();

   reg_write_arbiter #(
      .NUM_REQ   (4),
      .DATA_W    (4),
      .RESET_VAL (4'h0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   logic [3:0] bank = 4'h9;
   always @(posedge clk) bank <= bif.reg_d;
   assign bif.reg_q = bank;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bif.ack != 4'b0) ack_cnt <= ack_cnt + 1;
      if (!rst && mon_en) begin
         chk("gnt_ack_excl", 32'((bif.gnt != 4'b0) && (bif.ack != 4'b0)), 0);
         chk("gnt_onehot0", 32'($onehot0(bif.gnt)), 1);
         chk("ack_onehot0", 32'($onehot0(bif.ack)), 1);
      end
   end

   task automatic wait_gnt(output bit ok);
      int n = 0;
      while (bif.gnt == 4'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      ok = (bif.gnt != 4'b0);
      if (!ok) chk("gnt_timeout", 0, 1);
   endtask

   task automatic serve(input int idx, input int data, input bit drop, output int gcyc);
      bit ok;
      gcyc = 0;
      wait_gnt(ok);
      if (!ok) return;
      gcyc = cyc;
      chk("gnt", 32'(bif.gnt), 1 << idx);
      chk("ack_idle_in_write", 32'(bif.ack), 0);
      chk("reg_d_write", 32'(bif.reg_d), data);
      chk("busy_write", 32'(bif.busy), 1);
      @(negedge clk);
      chk("ack", 32'(bif.ack), 1 << idx);
      chk("gnt_clear", 32'(bif.gnt), 0);
      chk("reg_q", 32'(bif.reg_q), data);
      if (drop) bif.req[idx] = 1'b0;
   endtask

   initial begin
      int  g, gprev, ack_before;
      bit  ok;
      rst       = 1'b1;
      bif.req   = '0;
      bif.wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(bif.gnt), 0);
      chk("rst_ack", 32'(bif.ack), 0);
      chk("rst_busy", 32'(bif.busy), RST_BUSY);
      chk("rst_reg_d", 32'(bif.reg_d), 'h9);
      rst = 1'b0;
      @(negedge clk);
`ifdef REG_WRITE_ARBITER_INIT_WRITE_EN
      chk("init_val", 32'(bif.reg_q), 'h0);
`else
      chk("hold_after_rst", 32'(bif.reg_q), 'h9);
`endif
      chk("busy_after_rst", 32'(bif.busy), 0);
      mon_en = 1'b1;

      // all four held from ptr=0: served 0,1,2,3, one grant per 3 cycles
      bif.wdata = 16'h4321;
      bif.req   = 4'b1111;
      gprev = 0;
      for (int k = 0; k < 4; k++) begin
         serve(k, k + 1, 1'b1, g);
         if (k > 0) chk("rr_spacing", 32'(g - gprev), 3);
         gprev = g;
      end
      @(negedge clk);
      chk("busy_after_all", 32'(bif.busy), 0);

      // single request from requester 1, ptr wrapped back to 0
      bif.wdata = 16'h00A0;
      bif.req   = 4'b0010;
      serve(1, 'hA, 1'b1, g);
      @(negedge clk);
      chk("busy_n3", 32'(bif.busy), 0);

      // requester 0 alone from ptr=2 (wrap in scan), leaves ptr=1
      bif.wdata = 16'h0007;
      bif.req   = 4'b0001;
      serve(0, 'h7, 1'b1, g);
      @(negedge clk);

      // req=1001 with ptr=1: 3 first, then 0
      bif.wdata = 16'h6008;
      bif.req   = 4'b1001;
      serve(3, 'h6, 1'b1, g);
      serve(0, 'h8, 1'b1, g);
      @(negedge clk);
      chk("busy_after_1001", 32'(bif.busy), 0);

      // requester 2 changes data and drops req during WRITE
      bif.wdata = 16'h0500;
      bif.req   = 4'b0100;
      wait_gnt(ok);
      chk("gnt_r2", 32'(bif.gnt), 'b0100);
      bif.wdata = 16'h0F00;
      bif.req   = 4'b0000;
      @(negedge clk);
      chk("ack_r2_after_drop", 32'(bif.ack), 'b0100);
      chk("reg_q_latched", 32'(bif.reg_q), 'h5);
      @(negedge clk);
      chk("busy_after_drop", 32'(bif.busy), 0);

      // write 0xC then idle hold for 10 cycles
      bif.wdata = 16'hC000;
      bif.req   = 4'b1000;
      serve(3, 'hC, 1'b1, g);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle_reg_q", 32'(bif.reg_q), 'hC);
         chk("idle_reg_d", 32'(bif.reg_d), 'hC);
         chk("idle_gnt", 32'(bif.gnt), 0);
      end

      // reset asserted in the WRITE cycle
      bif.wdata = 16'h0008;
      bif.req   = 4'b0001;
      wait_gnt(ok);
      chk("gnt_before_rst", 32'(bif.gnt), 'b0001);
      ack_before = ack_cnt;
      rst = 1'b1;
      #1;
      chk("rst_mid_gnt", 32'(bif.gnt), 0);
      chk("rst_mid_ack", 32'(bif.ack), 0);
      chk("rst_mid_busy", 32'(bif.busy), RST_BUSY);
      chk("rst_mid_reg_d", 32'(bif.reg_d), 'hC);
      bif.req = 4'b0000;
      @(negedge clk);
      chk("rst_hold_reg_q", 32'(bif.reg_q), 'hC);
      rst = 1'b0;
      @(negedge clk);
`ifdef REG_WRITE_ARBITER_INIT_WRITE_EN
      chk("rst_init_reg_q", 32'(bif.reg_q), 'h0);
`else
      chk("rst_abandon_reg_q", 32'(bif.reg_q), 'hC);
`endif
      repeat (3) @(negedge clk);
      chk("no_ack_after_rst", 32'(ack_cnt - ack_before), 0);
      chk("busy_end", 32'(bif.busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
